// File: rtl/seg7_reg_viewer.sv
// Register-file viewer for active-low seven-segment digits: a three-frame boot banner
// while idle, and paged hex plus a decimal register index while enabled.
module seg7_reg_viewer #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int SEL_W       = 5,
    parameter int HEX_DIGITS  = 4,
    parameter int FRAME_TICKS = 100000000,
    localparam int PAGES      = DATA_W / (4 * HEX_DIGITS),
    localparam int PG_W       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [SEL_W-1:0]             reg_sel,
    input  logic [PG_W-1:0]              page_sel,
    input  logic                         auto_page,
    input  logic                         blank_lz,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [HEX_DIGITS*7-1:0]      seg_hex,
    output logic [13:0]                  seg_idx,
    output logic [PG_W-1:0]              page_out
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int TICK_W  = $clog2(FRAME_TICKS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        BANNER0,
        BANNER1,
        BANNER2,
        VIEW
    } state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0011000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    state_t              state;
    state_t              state_next;
    logic [TICK_W-1:0]   tick;
    logic                step;
    logic                mode_change;
    logic [PG_W-1:0]     page_reg;
    logic [PG_W-1:0]     clamped_sel;
    logic [PG_W-1:0]     eff_page;

    logic [DATA_W-1:0]   word_sel;
    logic                in_range;

    // Stage 1 capture registers
    logic [DATA_W-1:0]   word1;
    logic [SEL_W-1:0]    sel1;
    logic                oor1;
    logic [PG_W-1:0]     page1;
    logic                blz1;

    logic [NIBBLES-1:0]      nz_from;
    logic [HEX_DIGITS*7-1:0] view_hex;
    logic [31:0]             sel_wide;
    logic [3:0]              idx_tens;
    logic [3:0]              idx_units;

    logic [HEX_DIGITS*7-1:0] hex_next;
    logic [13:0]             idx_next;
    logic [PG_W-1:0]         page_next;

    assign step        = (tick == TICK_W'(FRAME_TICKS - 1));
    assign mode_change = en != (state == VIEW);
    assign clamped_sel = (32'(page_sel) > 32'(PAGES - 1)) ? PG_W'(PAGES - 1) : page_sel;
    assign eff_page    = auto_page ? page_reg : clamped_sel;
    assign in_range    = 32'(reg_sel) < 32'(NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BANNER0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (en && state != VIEW) begin
            state_next = VIEW;
        end else if (!en && state == VIEW) begin
            state_next = BANNER0;
        end else if (step) begin
            case (state)
                BANNER0: state_next = BANNER1;
                BANNER1: state_next = BANNER2;
                BANNER2: state_next = BANNER0;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || mode_change || step) begin
            tick <= '0;
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // In manual mode the page register tracks page_sel so auto-paging resumes from the shown page.
    always_ff @(posedge clk) begin
        if (reset) begin
            page_reg <= '0;
        end else if (state == VIEW && !mode_change) begin
            if (!auto_page) begin
                page_reg <= clamped_sel;
            end else if (step) begin
                page_reg <= (page_reg == PG_W'(PAGES - 1)) ? '0 : page_reg + PG_W'(1);
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (reg_sel == SEL_W'(r)) begin
                word_sel = regs_flat[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word1 <= '0;
            sel1  <= '0;
            oor1  <= 1'b0;
            page1 <= '0;
            blz1  <= 1'b0;
        end else begin
            word1 <= in_range ? word_sel : '0;
            sel1  <= reg_sel;
            oor1  <= !in_range;
            page1 <= eff_page;
            blz1  <= blank_lz;
        end
    end

    // nz_from[n] is set when nibble n or any more significant nibble is nonzero.
    always_comb begin
        nz_from = '0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            nz_from[n] = |(word1 >> (n * 4));
        end
    end

    always_comb begin
        view_hex = '1;
        for (int unsigned p = 0; p < PAGES; p++) begin
            if (32'(page1) == p) begin
                for (int unsigned i = 0; i < HEX_DIGITS; i++) begin
                    if (blz1 && !nz_from[p*HEX_DIGITS + i] && !(p == 0 && i == 0)) begin
                        view_hex[i*7 +: 7] = SEG_BLANK;
                    end else begin
                        view_hex[i*7 +: 7] = hex_glyph(word1[(p*HEX_DIGITS + i)*4 +: 4]);
                    end
                end
            end
        end
    end

    assign sel_wide  = 32'(sel1);
    assign idx_tens  = 4'(sel_wide / 32'd10);
    assign idx_units = 4'(sel_wide % 32'd10);

    always_comb begin
        hex_next  = '1;
        idx_next  = {SEG_BLANK, SEG_BLANK};
        page_next = page_out;
        case (state)
            BANNER0: begin
                idx_next = {7'b1100001, 7'b1000001};
                hex_next[(HEX_DIGITS-1)*7 +: 7] = 7'b0010010;
                hex_next[(HEX_DIGITS-2)*7 +: 7] = 7'b0000111;
            end
            BANNER1: begin
                idx_next = {7'b1000110, 7'b0001100};
                hex_next[(HEX_DIGITS-1)*7 +: 7] = 7'b1000001;
            end
            BANNER2: begin
                idx_next = {7'b0000011, 7'b0101111};
                hex_next[(HEX_DIGITS-1)*7 +: 7] = 7'b0100011;
            end
            default: begin
                hex_next  = view_hex;
                idx_next  = oor1 ? {SEG_DASH, SEG_DASH}
                                 : {hex_glyph(idx_tens), hex_glyph(idx_units)};
                page_next = page1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_hex  <= '1;
            seg_idx  <= '1;
            page_out <= '0;
        end else begin
            seg_hex  <= hex_next;
            seg_idx  <= idx_next;
            page_out <= page_next;
        end
    end

endmodule

// File: tb/tb_seg7_reg_viewer.sv
// Directed bench for seg7_reg_viewer: banner sequencing, resets, view-mode vectors,
// pipeline latency, clamping and auto-paging with a 48-bit, 20-register instance.
module tb_seg7_reg_viewer;

    localparam int DW = 48;
    localparam int NR = 20;
    localparam int SW = 5;
    localparam int HD = 4;
    localparam int FT = 4;
    localparam int PW = 2;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0011000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [SW-1:0]     reg_sel;
    logic [PW-1:0]     page_sel;
    logic              auto_page;
    logic              blank_lz;
    logic [NR*DW-1:0]  regs_flat;
    logic [HD*7-1:0]   seg_hex;
    logic [13:0]       seg_idx;
    logic [PW-1:0]     page_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [SW-1:0]   sel;
        logic [PW-1:0]   pg;
        logic            blz;
        logic [HD*7-1:0] hex;
        logic [13:0]     idx;
        logic [PW-1:0]   pout;
    } vec_t;

    vec_t vecs[16];

    seg7_reg_viewer #(
        .DATA_W(DW),
        .NUM_REGS(NR),
        .SEL_W(SW),
        .HEX_DIGITS(HD),
        .FRAME_TICKS(FT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .reg_sel(reg_sel),
        .page_sel(page_sel),
        .auto_page(auto_page),
        .blank_lz(blank_lz),
        .regs_flat(regs_flat),
        .seg_hex(seg_hex),
        .seg_idx(seg_idx),
        .page_out(page_out)
    );

    always #5 clk = ~clk;

    function automatic logic [HD*7-1:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                           input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int r, input logic [DW-1:0] v);
        regs_flat[r*DW +: DW] = v;
    endtask

    task automatic check(input string name, input logic [HD*7-1:0] eh,
                         input logic [13:0] ei, input logic [PW-1:0] ep);
        checks++;
        if (seg_hex !== eh || seg_idx !== ei || page_out !== ep) begin
            errors++;
            $display("FAIL %s: got hex=%h idx=%h page=%0d, want hex=%h idx=%h page=%0d",
                     name, seg_hex, seg_idx, page_out, eh, ei, ep);
        end
    endtask

    task automatic check_page(input string name, input logic [PW-1:0] ep);
        checks++;
        if (page_out !== ep) begin
            errors++;
            $display("FAIL %s: got page=%0d, want page=%0d", name, page_out, ep);
        end
    endtask

    task automatic check_banner(input string name, input int f);
        case (f)
            0: check(name, hx(7'b0010010, 7'b0000111, BL, BL), {7'b1100001, 7'b1000001}, 2'd0);
            1: check(name, hx(7'b1000001, BL, BL, BL), {7'b1000110, 7'b0001100}, 2'd0);
            default: check(name, hx(7'b0100011, BL, BL, BL), {7'b0000011, 7'b0101111}, 2'd0);
        endcase
    endtask

    initial begin
        logic [PW-1:0] v;
        bit seen;

        vecs[0]  = '{5'd11, 2'd0, 1'b0, hx(G0, G0, G0, GB), {G1, G1}, 2'd0};
        vecs[1]  = '{5'd11, 2'd1, 1'b0, hx(GD, GE, GA, GD), {G1, G1}, 2'd1};
        vecs[2]  = '{5'd11, 2'd3, 1'b0, hx(G0, G0, G0, G0), {G1, G1}, 2'd2};
        vecs[3]  = '{5'd11, 2'd2, 1'b1, hx(BL, BL, BL, BL), {G1, G1}, 2'd2};
        vecs[4]  = '{5'd11, 2'd0, 1'b1, hx(G0, G0, G0, GB), {G1, G1}, 2'd0};
        vecs[5]  = '{5'd5,  2'd0, 1'b1, hx(BL, BL, GA, G0), {G0, G5}, 2'd0};
        vecs[6]  = '{5'd5,  2'd1, 1'b1, hx(BL, BL, BL, BL), {G0, G5}, 2'd1};
        vecs[7]  = '{5'd0,  2'd0, 1'b1, hx(BL, BL, BL, G0), {G0, G0}, 2'd0};
        vecs[8]  = '{5'd0,  2'd1, 1'b0, hx(G0, G0, G0, G0), {G0, G0}, 2'd1};
        vecs[9]  = '{5'd19, 2'd2, 1'b0, hx(G1, G2, G3, G4), {G1, G9}, 2'd2};
        vecs[10] = '{5'd19, 2'd0, 1'b1, hx(G9, GA, GB, GC), {G1, G9}, 2'd0};
        vecs[11] = '{5'd25, 2'd0, 1'b1, hx(BL, BL, BL, G0), {DS, DS}, 2'd0};
        vecs[12] = '{5'd25, 2'd1, 1'b0, hx(G0, G0, G0, G0), {DS, DS}, 2'd1};
        vecs[13] = '{5'd20, 2'd0, 1'b0, hx(G0, G0, G0, G0), {DS, DS}, 2'd0};
        vecs[14] = '{5'd7,  2'd1, 1'b1, hx(BL, GF, G0, G0), {G0, G7}, 2'd1};
        vecs[15] = '{5'd5,  2'd0, 1'b0, hx(G0, G0, GA, G0), {G0, G5}, 2'd0};

        reset = 1'b1; en = 1'b0; reg_sel = '0; page_sel = '0;
        auto_page = 1'b0; blank_lz = 1'b0; regs_flat = '0;
        set_reg(4,  48'h5555_5555_5555);
        set_reg(5,  48'h0000_0000_00A0);
        set_reg(6,  48'h5555_5555_5555);
        set_reg(7,  48'h0000_0F00_0000);
        set_reg(10, 48'hFFFF_FFFF_FFFF);
        set_reg(11, 48'h0000_DEAD_000B);
        set_reg(12, 48'hFFFF_FFFF_FFFF);
        set_reg(19, 48'h1234_5678_9ABC);

        tick();
        check("reset_state", '1, '1, 2'd0);
        reset = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check_banner($sformatf("banner_c%0d", c), ((c - 1) / 4) % 3);
        end

        // Reset lands while the FSM is in BANNER1
        reset = 1'b1;
        tick();
        check("reset_mid_banner1", '1, '1, 2'd0);
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_banner($sformatf("after_reset_c%0d", c), ((c - 1) / 4) % 3);
        end

        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        tick();
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_banner($sformatf("en_restart_c%0d", c), ((c - 1) / 4) % 3);
        end

        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            reg_sel  = vecs[i].sel;
            page_sel = vecs[i].pg;
            blank_lz = vecs[i].blz;
            tick();
            tick();
            check($sformatf("vec%0d", i), vecs[i].hex, vecs[i].idx, vecs[i].pout);
        end

        reg_sel = 5'd11; page_sel = 2'd0; blank_lz = 1'b0;
        tick(); tick();
        check("lat_base", hx(G0, G0, G0, GB), {G1, G1}, 2'd0);
        reg_sel = 5'd19;
        tick();
        check("lat_sel_hold", hx(G0, G0, G0, GB), {G1, G1}, 2'd0);
        tick();
        check("lat_sel_new", hx(G9, GA, GB, GC), {G1, G9}, 2'd0);
        set_reg(19, 48'h1234_5678_FFFF);
        tick();
        check("lat_data_hold", hx(G9, GA, GB, GC), {G1, G9}, 2'd0);
        tick();
        check("lat_data_new", hx(GF, GF, GF, GF), {G1, G9}, 2'd0);

        // Auto-paging: page_sel=3 would clamp to 2 if it were not ignored
        auto_page = 1'b1;
        page_sel = 2'd3;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (page_out != 2'd0) seen = 1'b1;
        end
        checks++;
        if (!seen || page_out !== 2'd1) begin
            errors++;
            $display("FAIL auto_first_step: got page=%0d seen=%0d, want page=1", page_out, seen);
        end
        v = page_out;
        for (int k = 1; k < 12; k++) begin
            tick();
            check_page($sformatf("auto_k%0d", k), PW'((int'(v) + k / 4) % 3));
        end

        auto_page = 1'b0;
        page_sel = 2'd2;
        tick(); tick();
        check_page("auto_off_takes_sel", 2'd2);

        reset = 1'b1;
        tick();
        check("reset_in_view", '1, '1, 2'd0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
